seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver_pkg.sv | 51 +++++
 rtl/seg7_scan_driver_if.sv | 16 +
 rtl/seg7_scan_driver_decode.sv | 15 +
 rtl/seg7_scan_driver.sv | 135 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Shared segment patterns and nibble encoder for the seven-segment scan driver.
// Segment order is bit0 = a ... bit6 = g, active-high.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_A     = 7'b1110111;
   localparam logic [6:0] SEG_B     = 7'b1111100;
   localparam logic [6:0] SEG_C     = 7'b0111001;
   localparam logic [6:0] SEG_D     = 7'b1011110;
   localparam logic [6:0] SEG_E     = 7'b1111001;
   localparam logic [6:0] SEG_F     = 7'b1110001;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   // Nibble to segment pattern; in decimal mode 10..15 are dark.
   function automatic logic [6:0] seg7_encode(input logic [3:0] nibble, input logic hex_mode);
      logic [6:0] pat;
      pat = SEG_BLANK;
      case (nibble)
         4'h0:    pat = SEG_0;
         4'h1:    pat = SEG_1;
         4'h2:    pat = SEG_2;
         4'h3:    pat = SEG_3;
         4'h4:    pat = SEG_4;
         4'h5:    pat = SEG_5;
         4'h6:    pat = SEG_6;
         4'h7:    pat = SEG_7;
         4'h8:    pat = SEG_8;
         4'h9:    pat = SEG_9;
         4'hA:    pat = SEG_A;
         4'hB:    pat = SEG_B;
         4'hC:    pat = SEG_C;
         4'hD:    pat = SEG_D;
         4'hE:    pat = SEG_E;
         default: pat = SEG_F;
      endcase
      if (!hex_mode && (nibble > 4'd9)) begin
         pat = SEG_BLANK;
      end
      return pat;
   endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Value-load and display-pin bundle of the seven-segment scan driver.
interface seg7_scan_driver_if #(
   parameter int unsigned DIGITS = 4
);
   logic [4*DIGITS-1:0] value;
   logic                load;
   logic [DIGITS-1:0]   dp_in;
   logic                hex_mode;
   logic                en;
   logic [6:0]          seg;
   logic                dp;
   logic [DIGITS-1:0]   an;

   modport master (output value, load, dp_in, hex_mode, en, input seg, dp, an);
   modport slave  (input value, load, dp_in, hex_mode, en, output seg, dp, an);
endinterface

// File: rtl/seg7_scan_driver_decode.sv
// Combinational nibble-to-segment decoder, shared by all digits of the scan.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       hex_mode,
   output logic [6:0] seg_c
);

   // Pattern lookup for the currently selected nibble.
   always_comb begin
      seg_c = seg7_encode(nibble, hex_mode);
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with tear-free value loading.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned DIGITS      = 4,
   parameter int unsigned REFRESH_DIV = 50000
) (
   input  logic              clk,
   input  logic              rst,
   seg7_scan_driver_if.slave bus
);

   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   typedef logic [DIGITS-1:0][3:0] nibbles_t;

   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_next;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  idx_next;
   logic              step;
   logic              wrap;

   nibbles_t          shadow_val;
   logic [DIGITS-1:0] shadow_dp;
   nibbles_t          disp_val;
   logic [DIGITS-1:0] disp_dp;
   nibbles_t          disp_val_next;
   logic [DIGITS-1:0] disp_dp_next;

   logic [3:0]        nibble_c;
   logic              dp_c;
   logic [DIGITS-1:0] an_c;
   logic [6:0]        seg_c;
   logic [DIGITS-1:0] lead_blank;

   // Refresh divider and digit index; a wrap is the step leaving the last digit.
   always_comb begin
      cnt_next = cnt + CNT_W'(1);
      idx_next = idx;
      step     = (cnt == CNT_LAST);
      wrap     = step && (idx == IDX_LAST);
      if (step) begin
         cnt_next = '0;
         idx_next = wrap ? '0 : idx + IDX_W'(1);
      end
   end

   // Display registers take the shadow at a wrap, or the live input if loaded on that edge.
   always_comb begin
      disp_val_next = disp_val;
      disp_dp_next  = disp_dp;
      if (wrap) begin
         if (bus.load) begin
            disp_val_next = bus.value;
            disp_dp_next  = bus.dp_in;
         end else begin
            disp_val_next = shadow_val;
            disp_dp_next  = shadow_dp;
         end
      end
   end

   // Select the digit that will be lit after this edge.
   always_comb begin
      an_c           = '0;
      an_c[idx_next] = 1'b1;
      nibble_c       = disp_val_next[idx_next];
      dp_c           = disp_dp_next[idx_next];
   end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   // Digit k > 0 is blank when it and every higher display nibble are zero.
   always_comb begin
      logic higher_zero;
      higher_zero = 1'b1;
      lead_blank  = '0;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         if (disp_val_next[k] != 4'd0) begin
            higher_zero = 1'b0;
         end
         lead_blank[k] = higher_zero;
      end
   end
`else
   // Every digit is always decoded.
   always_comb begin
      lead_blank = '0;
   end
`endif

   seg7_decode u_decode (
      .nibble   (nibble_c),
      .hex_mode (bus.hex_mode),
      .seg_c    (seg_c)
   );

   // Scan state, shadow/display registers and registered pin outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         idx        <= '0;
         shadow_val <= '0;
         shadow_dp  <= '0;
         disp_val   <= '0;
         disp_dp    <= '0;
         bus.an     <= '0;
         bus.seg    <= SEG_BLANK;
         bus.dp     <= 1'b0;
      end else begin
         cnt      <= cnt_next;
         idx      <= idx_next;
         disp_val <= disp_val_next;
         disp_dp  <= disp_dp_next;
         if (bus.load) begin
            shadow_val <= bus.value;
            shadow_dp  <= bus.dp_in;
         end
         if (bus.en) begin
            bus.an  <= an_c;
            bus.seg <= lead_blank[idx_next] ? SEG_BLANK : seg_c;
            bus.dp  <= dp_c;
         end else begin
            bus.an  <= '0;
            bus.seg <= SEG_BLANK;
            bus.dp  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios followed by random stimulus,
// every edge compared against a cycle-count based reference model.
module tb_seg7_scan_driver;

   localparam int D  = 4;
   localparam int RD = 4;

   logic clk = 1'b0;
   logic rst;

   int checks = 0;
   int errors = 0;

   // Reference state: edges since reset release, shadow and displayed data.
   int          n;
   logic [15:0] sh_val, ds_val;
   logic [3:0]  sh_dp, ds_dp;
   logic [3:0]  exp_an;
   logic [6:0]  exp_seg;
   logic        exp_dp;

   seg7_scan_driver_if #(.DIGITS(D)) bus ();

   seg7_scan_driver #(.DIGITS(D), .REFRESH_DIV(RD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Segment table for a nibble, bit0 = a ... bit6 = g.
   function automatic logic [6:0] pattern(input logic [3:0] v, input logic hex);
      logic [6:0] p;
      case (v)
         4'h0: p = 7'b0111111;  4'h1: p = 7'b0000110;
         4'h2: p = 7'b1011011;  4'h3: p = 7'b1001111;
         4'h4: p = 7'b1100110;  4'h5: p = 7'b1101101;
         4'h6: p = 7'b1111101;  4'h7: p = 7'b0000111;
         4'h8: p = 7'b1111111;  4'h9: p = 7'b1101111;
         4'hA: p = 7'b1110111;  4'hB: p = 7'b1111100;
         4'hC: p = 7'b0111001;  4'hD: p = 7'b1011110;
         4'hE: p = 7'b1111001;  default: p = 7'b1110001;
      endcase
      if (!hex && v > 4'd9) p = 7'b0000000;
      return p;
   endfunction

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h (edge %0d)", tag, got, exp, n);
      end
   endtask

   // Advance the model by one edge using the inputs present at that edge.
   task automatic model_edge();
      int digit;
      logic [3:0] nib;
      logic blank;
      if (rst) begin
         n = 0; sh_val = '0; ds_val = '0; sh_dp = '0; ds_dp = '0;
         exp_an = '0; exp_seg = '0; exp_dp = 1'b0;
      end else begin
         n++;
         if (n % (RD * D) == 0) begin
            ds_val = bus.load ? bus.value : sh_val;
            ds_dp  = bus.load ? bus.dp_in : sh_dp;
         end
         if (bus.load) begin
            sh_val = bus.value;
            sh_dp  = bus.dp_in;
         end
         digit = (n / RD) % D;
         nib   = 4'(ds_val >> (4 * digit));
         blank = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
         blank = (digit > 0) && ((ds_val >> (4 * digit)) == 16'd0);
`endif
         if (bus.en) begin
            exp_an  = 4'(1 << digit);
            exp_seg = blank ? 7'b0000000 : pattern(nib, bus.hex_mode);
            exp_dp  = ds_dp[digit];
         end else begin
            exp_an = '0; exp_seg = '0; exp_dp = 1'b0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("an", 16'(bus.an), 16'(exp_an));
      chk("seg", 16'(bus.seg), 16'(exp_seg));
      chk("dp", 16'(bus.dp), 16'(exp_dp));
   endtask

   task automatic ticks(input int k);
      for (int i = 0; i < k; i++) tick();
   endtask

   initial begin
      n = 0; sh_val = '0; ds_val = '0; sh_dp = '0; ds_dp = '0;
      exp_an = '0; exp_seg = '0; exp_dp = 1'b0;
      rst = 1'b1;
      bus.value = 16'h0000; bus.load = 1'b0; bus.dp_in = 4'b0000;
      bus.hex_mode = 1'b0; bus.en = 1'b1;

      // Reset state
      ticks(2);
      chk("reset_an", 16'(bus.an), 16'h0);
      chk("reset_seg", 16'(bus.seg), 16'h0);
      rst = 1'b0;

      // First edge after release lights digit 0 with "0"
      tick();
      chk("first_an", 16'(bus.an), 16'b0001);
      chk("first_seg", 16'(bus.seg), 16'(7'b0111111));
      ticks(3);
      chk("step_an", 16'(bus.an), 16'b0010);

      // Load 1234 mid-scan; visible only at the wrap
      bus.value = 16'h1234; bus.load = 1'b1;
      tick();
      bus.load = 1'b0;
      ticks(11);
      chk("wrap_an", 16'(bus.an), 16'b0001);
      chk("wrap_digit0_4", 16'(bus.seg), 16'(7'b1100110));
      ticks(4);
      chk("digit1_3", 16'(bus.seg), 16'(7'b1001111));

      // Load coincident with the wrap is shown immediately
      ticks(11);
      bus.value = 16'h5678; bus.load = 1'b1;
      tick();
      bus.load = 1'b0;
      chk("fwd_an", 16'(bus.an), 16'b0001);
      chk("fwd_seg_8", 16'(bus.seg), 16'(7'b1111111));

      // Hex mode with ABCD and per-digit decimal points
      bus.hex_mode = 1'b1;
      bus.value = 16'hABCD; bus.dp_in = 4'b0101; bus.load = 1'b1;
      tick();
      bus.load = 1'b0;
      ticks(15);
      chk("hex_d", 16'(bus.seg), 16'(7'b1011110));
      chk("dp0", 16'(bus.dp), 16'h1);
      ticks(4);
      chk("hex_c", 16'(bus.seg), 16'(7'b0111001));
      ticks(4);
      chk("hex_b", 16'(bus.seg), 16'(7'b1111100));
      ticks(4);
      chk("hex_a", 16'(bus.seg), 16'(7'b1110111));

      // Decimal mode blanks A-F but keeps scanning
      bus.hex_mode = 1'b0;
      tick();
      chk("dec_blank_seg", 16'(bus.seg), 16'h0);
      chk("dec_blank_an", 16'(bus.an), 16'b1000);

      // Disable for 6 cycles, then resume mid-scan
      bus.en = 1'b0;
      ticks(6);
      chk("dark_an", 16'(bus.an), 16'h0);
      bus.en = 1'b1;
      tick();
      chk("resume_an", 16'(bus.an), 16'b0010);

      // Reset mid-scan discards the pending shadow load
      bus.value = 16'h9999; bus.load = 1'b1;
      tick();
      bus.load = 1'b0;
      rst = 1'b1;
      tick();
      chk("midrst_an", 16'(bus.an), 16'h0);
      chk("midrst_seg", 16'(bus.seg), 16'h0);
      rst = 1'b0;
      ticks(16);
      chk("post_rst_wrap", 16'(bus.seg), 16'(7'b0111111));

      // Leading zeros with 0070
      bus.value = 16'h0070; bus.dp_in = 4'b0000; bus.load = 1'b1;
      tick();
      bus.load = 1'b0;
      ticks(15);
      chk("lz_digit0", 16'(bus.seg), 16'(7'b0111111));
      ticks(4);
      chk("lz_digit1", 16'(bus.seg), 16'(7'b0000111));
      ticks(4);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      chk("lz_digit2", 16'(bus.seg), 16'(7'b0000000));
`else
      chk("lz_digit2", 16'(bus.seg), 16'(7'b0111111));
`endif

      // Random traffic against the model
      for (int i = 0; i < 800; i++) begin
         bus.value = 16'($urandom);
         bus.dp_in = 4'($urandom);
         bus.load  = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 31) == 0) bus.hex_mode = ~bus.hex_mode;
         if ($urandom_range(0, 23) == 0) bus.en = ~bus.en;
         rst = ($urandom_range(0, 199) == 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
